// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and default timing constants for the I2C write master
package i2c_pkg;

   localparam int DEFAULT_SPEED   = 400;
   localparam int DEFAULT_CLK_KHZ = 27000;

   typedef enum logic [2:0] {
      IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP
   } state_t;

   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_t;

   function automatic int qdiv(input int clk_khz, input int speed);
      return clk_khz / (4 * speed);
   endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - divider producing the SCL quarter-period tick and quarter index
module i2c_quarter_tick
   import i2c_pkg::*;
#(
   parameter int QDIV = 16
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   i_en,
   input  logic   i_phase_clr,
   output logic   o_tick,
   output phase_t o_phase
);

   localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

   logic [CW-1:0] r_cnt;
   phase_t        r_phase;

   assign o_tick  = i_en && (r_cnt == CW'(QDIV - 1));
   assign o_phase = r_phase;

   // i_phase_clr realigns the bit grid after the two-quarter START condition
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_phase <= Q0;
      end else if (!i_en) begin
         r_cnt   <= '0;
         r_phase <= Q0;
      end else if (o_tick) begin
         r_cnt   <= '0;
         r_phase <= i_phase_clr ? Q0 : phase_t'(r_phase + 2'd1);
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_controller.sv
// rtl/i2c_controller.sv - single-master write-only I2C controller (address byte + data bytes)
// Optional I2C_IGNORE_NACK_EN: NACK is flagged but never aborts the transfer.
module i2c_controller
   import i2c_pkg::*;
#(
   parameter int SPEED   = DEFAULT_SPEED,
   parameter int CLK_KHZ = DEFAULT_CLK_KHZ
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] address_in,
   input  logic [7:0] data_in,
   input  logic       send_additional_data,
   input  logic       SDA_IN,
   output logic       SCL,
   output wire        SDA_OUT,
   output logic       sending_data,
   output logic       busy,
   output logic       NACK,
   output logic       data_saved
);

   localparam int QDIV = qdiv(CLK_KHZ, SPEED);

   state_t     r_state;
   state_t     w_next;
   logic       w_tick;
   phase_t     w_phase;
   logic       w_phase_clr;
   logic       w_load_data;
   logic       w_bit_end;
   logic       w_abort;
   logic       w_sda;
   logic [7:0] r_shift;
   logic [2:0] r_bit;
   logic       r_nack;
   logic       r_data_saved;

   i2c_quarter_tick #(.QDIV(QDIV)) u_tick (
      .clk         (clk),
      .reset       (reset),
      .i_en        (r_state != IDLE),
      .i_phase_clr (w_phase_clr),
      .o_tick      (w_tick),
      .o_phase     (w_phase)
   );

   assign w_bit_end = w_tick && (w_phase == Q3);

`ifdef I2C_IGNORE_NACK_EN
   assign w_abort = 1'b0;
`else
   assign w_abort = r_nack;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_phase_clr = 1'b0;
      w_load_data = 1'b0;
      case (r_state)
         IDLE:  if (start) w_next = START;
         START: if (w_tick && w_phase == Q1) begin
            w_next      = ADDR;
            w_phase_clr = 1'b1;
         end
         ADDR:  if (w_bit_end && r_bit == 3'd0) w_next = ACK_A;
         DATA:  if (w_bit_end && r_bit == 3'd0) w_next = ACK_D;
         ACK_A: if (w_bit_end) begin
            if (w_abort) w_next = STOP;
            else begin
               w_next      = DATA;
               w_load_data = 1'b1;
            end
         end
         ACK_D: if (w_bit_end) begin
            if (w_abort || !send_additional_data) w_next = STOP;
            else begin
               w_next      = DATA;
               w_load_data = 1'b1;
            end
         end
         STOP:  if (w_tick && w_phase == Q2) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // SCL is low only in q0 of each bit; START holds it high across both of its quarters
   always_comb begin
      SCL          = 1'b1;
      w_sda        = 1'b1;
      sending_data = 1'b0;
      busy         = 1'b1;
      case (r_state)
         IDLE:  busy = 1'b0;
         START: begin
            sending_data = 1'b1;
            w_sda        = (w_phase == Q0);
         end
         ADDR, DATA: begin
            sending_data = 1'b1;
            SCL          = (w_phase != Q0);
            w_sda        = r_shift[7];
         end
         ACK_A, ACK_D: SCL = (w_phase != Q0);
         STOP: begin
            sending_data = 1'b1;
            SCL          = (w_phase != Q0);
            w_sda        = (w_phase == Q2);
         end
         default: busy = 1'b0;
      endcase
   end

   assign SDA_OUT    = sending_data ? w_sda : 1'bz;
   assign NACK       = r_nack;
   assign data_saved = r_data_saved;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift      <= '0;
         r_bit        <= 3'd7;
         r_nack       <= 1'b0;
         r_data_saved <= 1'b0;
      end else begin
         r_data_saved <= w_load_data;
         if (r_state == IDLE && start) begin
            r_shift <= address_in;
            r_bit   <= 3'd7;
            r_nack  <= 1'b0;
         end else if (w_load_data) begin
            r_shift <= data_in;
            r_bit   <= 3'd7;
         end else if ((r_state == ADDR || r_state == DATA) && w_bit_end) begin
            r_shift <= {r_shift[6:0], 1'b0};
            r_bit   <= r_bit - 3'd1;
         end
         if ((r_state == ACK_A || r_state == ACK_D) && w_tick && w_phase == Q2 && SDA_IN)
            r_nack <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i2c_controller.sv
// tb/tb_i2c_controller.sv - randomized bench with a bus-level decoder and slave model
`timescale 1ns/1ps
module tb_i2c_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] address_in = 8'h00;
   logic [7:0] data_in = 8'h00;
   logic       send_additional_data = 1'b0;
   logic       sda_in;
   logic       scl;
   wire        sda_out;
   logic       sending_data;
   logic       busy;
   logic       nack;
   logic       data_saved;

   int n_checks = 0;
   int n_errors = 0;

   i2c_controller dut (
      .clk                  (clk),
      .reset                (reset),
      .start                (start),
      .address_in           (address_in),
      .data_in              (data_in),
      .send_additional_data (send_additional_data),
      .SDA_IN               (sda_in),
      .SCL                  (scl),
      .SDA_OUT              (sda_out),
      .sending_data         (sending_data),
      .busy                 (busy),
      .NACK                 (nack),
      .data_saved           (data_saved)
   );

   always #18.5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // bus decoder and acknowledging slave (only the host process writes txn_id)
   int         txn_id = 0;
   int         slave_nack_slot = -1;
   int         mon_seen_id = 0;
   int         mon_bitcnt = 0;
   int         mon_nbytes = 0;
   int         mon_starts = 0;
   int         mon_stops = 0;
   int         mon_rises = 0;
   int         mon_saved = 0;
   int         mon_period_err = 0;
   int         mon_ackdrive_err = 0;
   int         mon_cyc = 0;
   int         mon_last_rise = 0;
   bit         mon_rise_valid = 0;
   logic       mon_prev_scl = 1'b1;
   logic       mon_prev_sda = 1'b1;
   logic [7:0] mon_cur = 8'h00;
   logic [7:0] rx_q[$];
   logic       ack_q[$];
   logic       slave_sda;

   assign slave_sda = (mon_bitcnt >= 8 && (mon_nbytes - 1) != slave_nack_slot) ? 1'b0 : 1'b1;
   assign sda_in    = sending_data ? sda_out : slave_sda;

   always @(negedge clk) begin
      mon_cyc++;
      if (reset || mon_seen_id != txn_id) begin
         mon_seen_id = txn_id;
         mon_bitcnt = 0; mon_nbytes = 0; mon_starts = 0; mon_stops = 0; mon_rises = 0;
         mon_saved = 0; mon_period_err = 0; mon_ackdrive_err = 0; mon_rise_valid = 0;
         rx_q.delete();
         ack_q.delete();
         mon_prev_scl = scl;
         mon_prev_sda = sda_in;
      end else begin
         if (data_saved) mon_saved++;
         if (mon_prev_scl && scl && mon_prev_sda && !sda_in) begin
            mon_starts++;
            mon_bitcnt = 0;
            mon_rise_valid = 0;
         end else if (mon_prev_scl && scl && !mon_prev_sda && sda_in) begin
            mon_stops++;
            mon_bitcnt = 0;
         end else if (!mon_prev_scl && scl) begin
            mon_rises++;
            if (mon_rise_valid && (mon_cyc - mon_last_rise) != 64) mon_period_err++;
            mon_last_rise = mon_cyc;
            mon_rise_valid = 1;
            if (mon_bitcnt < 8) begin
               mon_cur = {mon_cur[6:0], sda_in};
               mon_bitcnt++;
               if (mon_bitcnt == 8) begin
                  rx_q.push_back(mon_cur);
                  mon_nbytes++;
               end
            end else if (mon_bitcnt == 8) begin
               ack_q.push_back(sda_in);
               if (sending_data) mon_ackdrive_err++;
               mon_bitcnt = 9;
            end
         end else if (mon_prev_scl && !scl && mon_bitcnt == 9) begin
            mon_bitcnt = 0;
         end
         mon_prev_scl = scl;
         mon_prev_sda = sda_in;
      end
   end

   logic [7:0] tx_q[$];
   bit         model_nack = 0;

   task automatic run_txn(input logic [7:0] addr, input int nack_slot, input bit hold_start);
      int         nbytes, last_slot, host_k, guard, n;
      logic [7:0] exp_q[$];
      logic       exp_acks[$];
      bit         exp_nack;
      nbytes = tx_q.size();
      check("nack_held", nack, model_nack);
      exp_nack = (nack_slot >= 0 && nack_slot <= nbytes);
`ifdef I2C_IGNORE_NACK_EN
      last_slot = nbytes;
`else
      last_slot = exp_nack ? nack_slot : nbytes;
`endif
      exp_q.push_back(addr);
      for (int s = 1; s <= last_slot; s++) exp_q.push_back(tx_q[s-1]);
      for (int s = 0; s <= last_slot; s++) exp_acks.push_back(s == nack_slot);

      txn_id++;
      slave_nack_slot = nack_slot;
      address_in = addr;
      data_in = tx_q[0];
      send_additional_data = 1'b0;
      @(negedge clk);
      start = 1'b1;
      repeat (hold_start ? 200 : 3) @(negedge clk);
      start = 1'b0;
      host_k = 0;
      guard = 0;
      while (busy && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (data_saved) begin
            host_k++;
            data_in = (host_k < nbytes) ? tx_q[host_k] : 8'($urandom);
            send_additional_data = (host_k < nbytes);
         end
      end
      check("txn_timeout", guard >= 20000, 0);
      repeat (4) @(negedge clk);
      check("busy_end", busy, 0);
      check("nack_flag", nack, exp_nack);
      check("start_cond", mon_starts, 1);
      check("stop_cond", mon_stops, 1);
      check("byte_count", rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
      check("ack_count", ack_q.size(), exp_acks.size());
      n = (ack_q.size() < exp_acks.size()) ? ack_q.size() : exp_acks.size();
      for (int i = 0; i < n; i++) check($sformatf("ack%0d", i), ack_q[i], exp_acks[i]);
      check("scl_rises", mon_rises, 9 * exp_q.size() + 1);
      check("scl_period", mon_period_err, 0);
      check("ack_released", mon_ackdrive_err, 0);
      check("data_saved_cnt", mon_saved, last_slot);
      model_nack = exp_nack;
   endtask

   initial begin
      int bad, guard, nb, ns;
      repeat (4) @(negedge clk);
      check("rst_scl", scl, 1);
      check("rst_busy", busy, 0);
      check("rst_sending", sending_data, 0);
      check("rst_nack", nack, 0);
      check("rst_saved", data_saved, 0);
      reset = 1'b0;
      bad = 0;
      repeat (135) begin
         @(negedge clk);
         if (scl !== 1'b1 || busy !== 1'b0 || sending_data !== 1'b0 || nack !== 1'b0 || data_saved !== 1'b0)
            bad++;
      end
      check("idle_quiet", bad, 0);

      tx_q = '{8'hA5, 8'h5A};
      run_txn(8'h78, -1, 0);
      tx_q = '{8'hA5};
      run_txn(8'h78, 0, 0);
      tx_q = '{8'h3C, 8'h81};
      run_txn(8'h3D, 2, 0);
      tx_q = '{8'h11, 8'h22};
      run_txn(8'h78, -1, 1);
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (busy !== 1'b0) bad++;
      end
      check("start_not_queued", bad, 0);

      for (int t = 0; t < 8; t++) begin
         nb = $urandom_range(1, 3);
         ns = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb) : -1;
         tx_q.delete();
         for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
         run_txn(8'($urandom), ns, 0);
      end

      txn_id++;
      slave_nack_slot = -1;
      address_in = 8'h78;
      data_in = 8'hC3;
      send_additional_data = 1'b1;
      @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!data_saved && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("reset_txn_saved", guard >= 5000, 0);
      repeat (150) @(negedge clk);
      check("mid_data_busy", busy, 1);
      #3 reset = 1'b1;
      #1;
      check("async_rst_scl", scl, 1);
      check("async_rst_busy", busy, 0);
      check("async_rst_sending", sending_data, 0);
      @(negedge clk);
      reset = 1'b0;
      model_nack = 0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (scl !== 1'b1 || busy !== 1'b0 || sending_data !== 1'b0) bad++;
      end
      check("post_reset_idle", bad, 0);

      tx_q = '{8'hE7};
      run_txn(8'h78, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/i2c_controller.md
Name: i2c_controller

Overview:
- Single-master, write-only I2C controller that serialises one address byte followed by one or more data bytes onto SCL/SDA.
- Serves as the GPU's display-link master (e.g. SSD1306 at 0x78 write).
- Host pulses start, supplies data_in per byte, and chains bytes with send_additional_data.
- Runs from the 27 MHz system clock.

Parameters:
- SPEED, 400, target SCL frequency in kHz.
- CLK_KHZ, 27000, system clock frequency in kHz.
- QDIV, CLK_KHZ/(4*SPEED) (integer, =16), clk cycles per SCL quarter-period; SCL period = 4*QDIV clocks.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin transaction; level-sampled, ignored while busy.
- address_in  in  8  7-bit address + R/W bit, sent MSB-first as-is.
- data_in  in  8  next data byte, latched at each data-byte start.
- send_additional_data  in  1  sampled after each data ACK: 1 = send another byte, 0 = STOP.
- SDA_IN  in  1  resolved SDA line, used for ACK sampling.
- SCL  out  1  I2C clock, idle high.
- SDA_OUT  out(tri)  1  driven 0/1 while sending_data=1, high-Z otherwise.
- sending_data  out  1  controller owns SDA.
- busy  out  1  transaction in progress.
- NACK  out  1  sticky: last ACK slot read 1.
- data_saved  out  1  1-cycle pulse when data_in is latched.

Behaviour:
- Reset (async): state IDLE, SCL=1, sending_data=0, SDA_OUT=Z, busy=0, NACK=0, data_saved=0, divider cleared.
- Quarter-tick: divider counts 0..QDIV-1 and emits a tick at wrap. It runs only when not IDLE and is cleared on leaving IDLE.
- Bit timing (4 quarters per bit):
  - q0: SCL=0, SDA updated.
  - q1: SCL rises.
  - q2: mid-high; ACK sampled here.
  - q3: SCL falls at end.
- States:
  - IDLE: on start=1 and not busy, latch address_in into the shift register, clear NACK, busy=1, go to START.
  - START: sending_data=1, SDA=1 with SCL=1 for 1 quarter, then SDA=0 (SCL high) for 1 quarter, then SCL=0; go to ADDR.
  - ADDR: 8 bits, MSB first; go to ACK_A.
  - ACK_A / ACK_D: sending_data=0 (SDA_OUT Z) for the full bit. SDA_IN sampled at q2; 1 sets NACK.
    - On NACK: go to STOP.
    - Otherwise from ACK_A: latch data_in, pulse data_saved, go to DATA.
    - Otherwise from ACK_D: if send_additional_data=1 (sampled at end of ACK bit), latch data_in, pulse data_saved, go to DATA; else go to STOP.
  - DATA: 8 bits MSB first; go to ACK_D.
  - STOP: sending_data=1, SDA=0 with SCL=0 (1 quarter), SCL=1 (1 quarter), SDA=1 (1 quarter); then sending_data=0, busy=0, go to IDLE.
- SDA changes only while SCL=0, except in START and STOP.
- data_saved pulses exactly once per data byte, one clk wide, on the clk data_in is captured. The host may change data_in from the following cycle.
- start asserted during busy is ignored; it is not queued.
- NACK holds until the next accepted start or reset.
- Reset mid-transfer: immediate return to IDLE; the bus is released (SCL=1, SDA Z). No STOP is generated.

Optional Feature:
- Macro: I2C_IGNORE_NACK_EN.
- Defined: NACK is still flagged, but the ACK outcome never forces STOP; flow continues as if ACKed.
- Undefined: NACK aborts to STOP as specified above.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP)
  - quarter-phase enum (Q0..Q3)
  - default SPEED/CLK_KHZ constants
- Sub-module i2c_quarter_tick: parameterised divider producing the quarter-period tick and phase index.

Test Plan:
- Reset then idle: SCL=1, busy=0, sending_data=0, SDA_OUT=Z, NACK=0 for 5 µs with start=0.
- start pulse 100 ns, address_in=0x78, ACK driven 0:
  - START condition appears.
  - Bits 0,1,1,1,1,0,0,0 are sampled on SCL rising edges.
  - SCL period = 64 clk (~2.37 µs).
  - sending_data=0 during the 9th bit.
- After address ACK: data_saved pulses once, then data byte 0xA5 is sent. Update data_in to 0x5A after the pulse with send_additional_data=1 → second byte 0x5A follows.
- send_additional_data=0 before the second data ACK → STOP (SDA rises while SCL=1), then busy=0.
- Address ACK slot left high → NACK=1, STOP, busy=0.
  - With I2C_IGNORE_NACK_EN: NACK=1 but the data byte is still sent.
- start held high during busy → no second transaction. Assert reset mid-DATA → SCL=1, SDA_OUT=Z, busy=0 asynchronously.
